// File: rtl/xnor_based_cla16_xor_enc32_if.sv
// Operand/key/result bundle for the key-locked 16-bit CLA.
// The master drives operands and key; the slave returns the registered sum.
interface xnor_based_cla16_xor_enc32_if;
  logic [15:0] add1_i;
  logic [15:0] add2_i;
  logic [31:0] keyinput;
  logic [16:0] result_o;

  modport master (
    output add1_i,
    output add2_i,
    output keyinput,
    input  result_o
  );

  modport slave (
    input  add1_i,
    input  add2_i,
    input  keyinput,
    output result_o
  );
endinterface

// File: rtl/xnor_based_cla16_xor_enc32.sv
// 16-bit two-level carry-lookahead adder whose propagate/generate nets pass through
// 32 XOR/XNOR key gates; only the correct key (or a paired-flip equivalent) yields a+b.
module xnor_based_cla16_xor_enc32 (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  xnor_based_cla16_xor_enc32_if.slave  bus
);

  localparam int unsigned W     = 16;
  localparam int unsigned KW    = 32;
  localparam int unsigned GRP   = 4;
  localparam int unsigned NGRP  = W / GRP;
  localparam logic [KW-1:0] KEY_C = 32'h094F5C9D;

  logic [W-1:0]   w_p;
  logic [W-1:0]   w_g;
  logic [W-1:0]   w_p1;
  logic [W-1:0]   w_pk;
  logic [W-1:0]   w_gk;
  logic [W-1:0]   w_c;
  logic [W-1:0]   w_s;
  logic [NGRP-1:0] w_gg;
  logic [NGRP-1:0] w_pg;
  logic [NGRP:0]   w_cg;
  logic [W:0]      r_result;

  // Raw propagate/generate per bit.
  always_comb begin
    w_p = '0;
    w_g = '0;
    for (int k = 0; k < int'(W); k++) begin
      w_p[k] = ~(~(bus.add1_i[k] ^ bus.add2_i[k]));
      w_g[k] = bus.add1_i[k] & bus.add2_i[k];
    end
  end

  // First key-gate stage on propagate; p_9 is left bare because key[9] guards p_4.
  for (genvar k = 0; k < int'(W); k++) begin : g_pgate1
    if (k == 9) begin : g_bare
      assign w_p1[k] = w_p[k];
    end else if (KEY_C[k]) begin : g_xnor
      assign w_p1[k] = ~(w_p[k] ^ bus.keyinput[k]);
    end else begin : g_xor
      assign w_p1[k] = w_p[k] ^ bus.keyinput[k];
    end
  end

  // Second, series key gates: key[16] on p_3 and key[9] on p_4, so paired flips cancel.
  for (genvar k = 0; k < int'(W); k++) begin : g_pgate2
    if (k == 3) begin : g_p3
      if (KEY_C[16]) begin : g_xnor
        assign w_pk[k] = ~(w_p1[k] ^ bus.keyinput[16]);
      end else begin : g_xor
        assign w_pk[k] = w_p1[k] ^ bus.keyinput[16];
      end
    end else if (k == 4) begin : g_p4
      if (KEY_C[9]) begin : g_xnor
        assign w_pk[k] = ~(w_p1[k] ^ bus.keyinput[9]);
      end else begin : g_xor
        assign w_pk[k] = w_p1[k] ^ bus.keyinput[9];
      end
    end else begin : g_pass
      assign w_pk[k] = w_p1[k];
    end
  end

  // Generate key gates: key[17+j] on g_j for j=0..14; g_15 stays ungated.
  for (genvar j = 0; j < int'(W); j++) begin : g_ggate
    if (j == int'(W) - 1) begin : g_bare
      assign w_gk[j] = w_g[j];
    end else if (KEY_C[17+j]) begin : g_xnor
      assign w_gk[j] = ~(w_g[j] ^ bus.keyinput[17+j]);
    end else begin : g_xor
      assign w_gk[j] = w_g[j] ^ bus.keyinput[17+j];
    end
  end

  // Two-level lookahead: group G/P, boundary carries, then in-group carries.
  always_comb begin
    int unsigned b;
    logic [GRP-1:0] gv;
    logic [GRP-1:0] pv;
    logic           cin;
    w_gg = '0;
    w_pg = '0;
    w_cg = '0;
    w_c  = '0;
    b    = 0;
    gv   = '0;
    pv   = '0;
    cin  = 1'b0;

    for (int i = 0; i < int'(NGRP); i++) begin
      b  = 32'(i) * GRP;
      gv = w_gk[b +: GRP];
      pv = w_pk[b +: GRP];
      w_gg[i] = gv[3] | (pv[3] & gv[2]) | (pv[3] & pv[2] & gv[1])
              | (pv[3] & pv[2] & pv[1] & gv[0]);
      w_pg[i] = &pv;
    end

    w_cg[0] = 1'b0;
    w_cg[1] = w_gg[0] | (w_pg[0] & w_cg[0]);
    w_cg[2] = w_gg[1] | (w_pg[1] & w_gg[0]) | (w_pg[1] & w_pg[0] & w_cg[0]);
    w_cg[3] = w_gg[2] | (w_pg[2] & w_gg[1]) | (w_pg[2] & w_pg[1] & w_gg[0])
            | (w_pg[2] & w_pg[1] & w_pg[0] & w_cg[0]);
    w_cg[4] = w_gg[3] | (w_pg[3] & w_gg[2]) | (w_pg[3] & w_pg[2] & w_gg[1])
            | (w_pg[3] & w_pg[2] & w_pg[1] & w_gg[0])
            | (w_pg[3] & w_pg[2] & w_pg[1] & w_pg[0] & w_cg[0]);

    for (int i = 0; i < int'(NGRP); i++) begin
      b   = 32'(i) * GRP;
      gv  = w_gk[b +: GRP];
      pv  = w_pk[b +: GRP];
      cin = w_cg[i];
      w_c[b]     = cin;
      w_c[b + 1] = gv[0] | (pv[0] & cin);
      w_c[b + 2] = gv[1] | (pv[1] & gv[0]) | (pv[1] & pv[0] & cin);
      w_c[b + 3] = gv[2] | (pv[2] & gv[1]) | (pv[2] & pv[1] & gv[0])
                 | (pv[2] & pv[1] & pv[0] & cin);
    end
  end

  always_comb begin
    w_s = '0;
    for (int k = 0; k < int'(W); k++) begin
      w_s[k] = ~(~(w_pk[k] ^ w_c[k]));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_result <= '0;
    end else begin
      r_result <= {w_cg[NGRP], w_s};
    end
  end

  assign bus.result_o = r_result;

endmodule

// File: tb/tb_xnor_based_cla16_xor_enc32.sv
// Directed and random checks of the key-locked CLA: reset, correct and
// equivalent keys, single-bit key faults and a multi-bit key corruption sweep.
module tb_xnor_based_cla16_xor_enc32;

  localparam logic [31:0] KEY_OK  = 32'h094F5C9D;
  localparam logic [31:0] KEY_EQ1 = 32'h094F5E8D;
  localparam logic [31:0] KEY_EQ2 = 32'h094E5E85;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  xnor_based_cla16_xor_enc32_if bus_if ();

  xnor_based_cla16_xor_enc32 dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one operand/key set between edges and sample 1 time unit after the capturing edge.
  task automatic apply(input logic [15:0] a, input logic [15:0] b, input logic [31:0] k);
    @(negedge clk);
    bus_if.add1_i   = a;
    bus_if.add2_i   = b;
    bus_if.keyinput = k;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n           = 1'b0;
    bus_if.add1_i   = 16'hFFFF;
    bus_if.add2_i   = 16'hFFFF;
    bus_if.keyinput = KEY_OK;
    #1;
    n_checks++;
    if (bus_if.result_o !== 17'h00000) begin
      n_fail++;
      $display("FAIL reset_initial: got %h expected %h", bus_if.result_o, 17'h00000);
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus_if.result_o !== 17'h00000) begin
      n_fail++;
      $display("FAIL reset_held: got %h expected %h", bus_if.result_o, 17'h00000);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus_if.result_o !== 17'h1FFFE) begin
      n_fail++;
      $display("FAIL reset_first_load: got %h expected %h", bus_if.result_o, 17'h1FFFE);
    end
    apply(16'hFFFF, 16'h0001, KEY_OK);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus_if.result_o !== 17'h00000) begin
      n_fail++;
      $display("FAIL reset_async_clear: got %h expected %h", bus_if.result_o, 17'h00000);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_correct_key();
    logic [15:0] va [4] = '{16'hFFFF, 16'h1234, 16'hFFFF, 16'h0000};
    logic [15:0] vb [4] = '{16'h0001, 16'h4321, 16'hFFFF, 16'h0000};
    logic [16:0] ve [4] = '{17'h10000, 17'h05555, 17'h1FFFE, 17'h00000};
    for (int i = 0; i < 4; i++) begin
      apply(va[i], vb[i], KEY_OK);
      n_checks++;
      if (bus_if.result_o !== ve[i]) begin
        n_fail++;
        $display("FAIL correct_key_vec%0d: got %h expected %h", i, bus_if.result_o, ve[i]);
      end
    end
  endtask

  task automatic test_random(input logic [31:0] k, input int n, input string tag);
    logic [15:0] a;
    logic [15:0] b;
    logic [16:0] exp_sum;
    int          bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      exp_sum = 17'(a) + 17'(b);
      apply(a, b, k);
      n_checks++;
      if (bus_if.result_o !== exp_sum) begin
        n_fail++;
        bad++;
        if (bad <= 5)
          $display("FAIL %s a=%h b=%h: got %h expected %h", tag, a, b, bus_if.result_o, exp_sum);
      end
    end
  endtask

  task automatic test_single_bit_keys();
    logic [31:0] kk [3] = '{32'h094F5C8D, 32'h094D5C9D, 32'h094F5C9C};
    logic [16:0] ke [3] = '{17'h00010, 17'h00002, 17'h00001};
    for (int i = 0; i < 3; i++) begin
      apply(16'h0000, 16'h0000, kk[i]);
      n_checks++;
      if (bus_if.result_o !== ke[i]) begin
        n_fail++;
        $display("FAIL single_bit_key %h: got %h expected %h", kk[i], bus_if.result_o, ke[i]);
      end
    end
  endtask

  // Key switching every cycle must take effect on the very next edge.
  task automatic test_back_to_back();
    logic [31:0] kk [4] = '{KEY_OK, 32'h094F5C9C, KEY_EQ2, 32'h094F5C8D};
    logic [16:0] ke [4] = '{17'h00000, 17'h00001, 17'h00000, 17'h00010};
    for (int i = 0; i < 4; i++) begin
      apply(16'h0000, 16'h0000, kk[i]);
      n_checks++;
      if (bus_if.result_o !== ke[i]) begin
        n_fail++;
        $display("FAIL back_to_back_%0d: got %h expected %h", i, bus_if.result_o, ke[i]);
      end
    end
  endtask

  task automatic test_key_sweep();
    logic [31:0] kk [4] = '{32'h094F5C0D, 32'h094F5C6E, 32'hFF4F5C9D, 32'h0948EC9D};
    logic [15:0] a;
    logic [15:0] b;
    int          miss;
    for (int i = 0; i < 4; i++) begin
      miss = 0;
      for (int j = 0; j < 200; j++) begin
        a = 16'($urandom);
        b = 16'($urandom);
        apply(a, b, kk[i]);
        if (bus_if.result_o !== (17'(a) + 17'(b))) miss++;
      end
      n_checks++;
      if (miss == 0) begin
        n_fail++;
        $display("FAIL key_sweep %h: got %0d mismatches expected nonzero", kk[i], miss);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_correct_key();
    test_random(KEY_OK, 20000, "random_correct_key");
    test_random(KEY_EQ1, 2000, "random_equiv_key1");
    test_random(KEY_EQ2, 2000, "random_equiv_key2");
    test_single_bit_keys();
    test_back_to_back();
    test_key_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
